avgp_out_drain_ctrl: RTL and testbench
======================================

# avgp_out_drain_ctrl

Sequencing controller for the output-alignment FIFO that follows the 3x3 average-pooling core. It counts core results written into the FIFO and delays reads until a programmable fill level is reached, then streams them out. At end of frame it drains the FIFO completely and flags frame completion. It replaces the free-running "read once full" logic, so partial frames and frames smaller than the FIFO depth still drain.

## Interface
Parameters:
- IMAGE_WIDTH, 16, output pixels per row
- IMAGE_HEIGHT, 16, output rows
- CHANNEL_NUM, 512, channels per frame
- FILL_LEVEL, 256, FIFO occupancy that starts streaming (1..FIFO_DEPTH)
- FIFO_DEPTH, 1024, FIFO capacity in words
- CNT_WIDTH, 18, frame counter width (must hold IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- valid_core  in  1  core result present this cycle (drives FIFO wr_en)
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- rd_en  out  1  FIFO read enable, registered
- valid_out  out  1  FIFO dout valid this cycle, registered
- frame_done  out  1  one-cycle pulse when the last pixel of a frame leaves the FIFO
- ovf_err  out  1  sticky: a write was attempted while full
- occupancy  out  log2(FIFO_DEPTH)+1  tracked FIFO word count

## Operation
- TOTAL = IMAGE_WIDTH*IMAGE_HEIGHT*CHANNEL_NUM (131072 at defaults).
- Accepted write: valid_core & !fifo_full. It increments occupancy and wr_cnt.
- Accepted read: rd_en & !fifo_empty. It decrements occupancy and increments rd_cnt.
- A write and a read in the same cycle leave occupancy unchanged.
- Write while full: data is lost, nothing is counted, ovf_err is set and stays set until reset.
- rd_en while empty: ignored, nothing is counted.
- FSM states:
  - IDLE: rd_en=0. The first accepted write moves to FILL.
  - FILL: rd_en=0. Moves to STREAM when occupancy (after this cycle's update) >= FILL_LEVEL, or when wr_cnt reaches TOTAL.
  - STREAM: rd_en=1. Moves to DONE when rd_cnt reaches TOTAL.
  - DONE: one cycle. frame_done=1, wr_cnt and rd_cnt clear, then IDLE.
- A write arriving in DONE or IDLE is counted toward the next frame. Back-to-back frames therefore lose nothing.
- Reset mid-frame: all counters clear and the state returns to IDLE. The external FIFO is reset by the same reset.

## Timing
- Reset values: rd_en=0, valid_out=0, frame_done=0, ovf_err=0, occupancy=0, state=IDLE.
- rd_en is registered from next-state: it rises the cycle after the FILL→STREAM condition is met and falls the cycle after the last read is accepted.
- FIFO is standard (non-FWFT).
  - valid_out(t+1) = rd_en(t) & !fifo_empty(t), aligned with FIFO dout.
- frame_done rises in the cycle after the final accepted read, which is the same cycle valid_out shows the final pixel.
- Fill-to-first-output latency is 2 cycles after occupancy reaches FILL_LEVEL: one cycle for rd_en, one for the FIFO read.
- Counters saturate at their maxima and never wrap.

## Structure
- Package avgp_ctrl_pkg holds:
  - state enum (IDLE, FILL, STREAM, DONE), 2-bit encoding
  - function computing TOTAL
  - clog2 helper
- Sub-module fifo_occ_counter: up/down occupancy counter with simultaneous inc/dec and saturation. It is instantiated once.
- FSM, frame counters and output registers live in the top.

## Test plan
Benches use IMAGE_WIDTH=4, IMAGE_HEIGHT=4, CHANNEL_NUM=2 (TOTAL=32), FILL_LEVEL=8 and FIFO_DEPTH=16, with a behavioural FIFO model.
- Continuous valid_core for 32 cycles:
  - rd_en rises exactly 1 cycle after the 8th write.
  - 32 valid_out pulses occur, in order.
  - frame_done pulses once, with the 32nd valid_out.
  - ovf_err stays 0.
- Valid_core every 3rd cycle (96 cycles):
  - rd_en stays low until occupancy reaches 8.
  - valid_out gaps occur whenever fifo_empty.
  - Totals match the first scenario: 32 valid_out, one frame_done.
- FILL_LEVEL=16 with only the full 32-pixel frame:
  - streaming starts at occupancy 16.
  - valid_out totals 32 and frame_done fires.
- Force fifo_full=1 during 1 write:
  - ovf_err=1 and stays 1.
  - wr_cnt does not increment.
- Assert reset asynchronously mid-STREAM, between clock edges:
  - all outputs go to 0 immediately.
  - After release, a clean 32-pixel frame yields 32 valid_out and one frame_done.
- Two frames back-to-back with a write landing in the DONE cycle:
  - 64 valid_out and 2 frame_done pulses.
  - The second frame counts that write.

Source files
------------

// File: rtl/avgp_out_drain_ctrl_pkg.sv
// avgp_ctrl_pkg: shared types and elaboration-time helpers for the
// average-pooling output drain controller.
//   drain_state_t : controller state (IDLE, FILL, STREAM, DONE), 2-bit code
//   frame_total() : pixels per frame = width * height * channels
//   clog2()       : ceiling log2 used to size the occupancy counter
package avgp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } drain_state_t;

    function automatic int unsigned frame_total(input int unsigned width,
                                                input int unsigned height,
                                                input int unsigned channels);
        return width * height * channels;
    endfunction

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/avgp_out_drain_ctrl_occ.sv
// fifo_occ_counter: up/down word counter mirroring the external FIFO fill.
// Simultaneous inc/dec cancel; the count saturates at 0 and at DEPTH.
//   clk, reset  : clock, asynchronous active-high reset
//   inc, dec    : accepted write / accepted read this cycle
//   count       : registered occupancy
//   count_next  : occupancy after this cycle's update (feeds the FSM)
module fifo_occ_counter #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(DEPTH);

    always_comb begin
        count_next = count;
        if (inc && !dec && count != MAX_COUNT) begin
            count_next = count + WIDTH'(1);
        end else if (dec && !inc && count != '0) begin
            count_next = count - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/avgp_out_drain_ctrl.sv
// avgp_out_drain_ctrl: holds FIFO reads back until FILL_LEVEL words are
// buffered (or the whole frame has been written), then streams until every
// pixel of the frame has been read, pulses frame_done and rearms.
//   clk, reset  : clock, asynchronous active-high reset
//   valid_core  : core result written to the FIFO this cycle
//   fifo_full   : FIFO full flag
//   fifo_empty  : FIFO empty flag
//   rd_en       : FIFO read enable (registered)
//   valid_out   : FIFO dout valid (registered, aligned with non-FWFT dout)
//   frame_done  : one-cycle pulse alongside the last pixel of a frame
//   ovf_err     : sticky, a write was attempted while full
//   occupancy   : tracked FIFO word count
module avgp_out_drain_ctrl
    import avgp_ctrl_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH  = 16,
    parameter int unsigned IMAGE_HEIGHT = 16,
    parameter int unsigned CHANNEL_NUM  = 512,
    parameter int unsigned FILL_LEVEL   = 256,
    parameter int unsigned FIFO_DEPTH   = 1024,
    parameter int unsigned CNT_WIDTH    = 18
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         valid_core,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    output logic                         rd_en,
    output logic                         valid_out,
    output logic                         frame_done,
    output logic                         ovf_err,
    output logic [clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int unsigned TOTAL = frame_total(IMAGE_WIDTH, IMAGE_HEIGHT, CHANNEL_NUM);
    localparam int unsigned OCC_W = clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_WIDTH-1:0] TOTAL_C = CNT_WIDTH'(TOTAL);
    localparam logic [OCC_W-1:0]     FILL_C  = OCC_W'(FILL_LEVEL);

    drain_state_t         state;
    drain_state_t         next_state;
    logic                 wr_acc;
    logic                 rd_acc;
    logic [CNT_WIDTH-1:0] wr_cnt;
    logic [CNT_WIDTH-1:0] rd_cnt;
    logic [CNT_WIDTH-1:0] wr_cnt_inc;
    logic [CNT_WIDTH-1:0] rd_cnt_inc;
    logic [OCC_W-1:0]     occ_next;

    assign wr_acc = valid_core && !fifo_full;
    assign rd_acc = rd_en && !fifo_empty;

    fifo_occ_counter #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OCC_W)
    ) u_occ (
        .clk        (clk),
        .reset      (reset),
        .inc        (wr_acc),
        .dec        (rd_acc),
        .count      (occupancy),
        .count_next (occ_next)
    );

    // Frame counters saturate at TOTAL so an overlong frame never wraps.
    always_comb begin
        wr_cnt_inc = wr_cnt;
        rd_cnt_inc = rd_cnt;
        if (wr_acc && wr_cnt != TOTAL_C) begin
            wr_cnt_inc = wr_cnt + CNT_WIDTH'(1);
        end
        if (rd_acc && rd_cnt != TOTAL_C) begin
            rd_cnt_inc = rd_cnt + CNT_WIDTH'(1);
        end
    end

    // A write taken during DONE already belongs to the next frame, so IDLE
    // also leaves on a non-zero wr_cnt rather than waiting for another write.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (wr_acc || wr_cnt != '0) begin
                    next_state = FILL;
                end
            end
            FILL: begin
                if (occ_next >= FILL_C || wr_cnt_inc >= TOTAL_C) begin
                    next_state = STREAM;
                end
            end
            STREAM: begin
                if (rd_cnt_inc == TOTAL_C) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else if (state == DONE) begin
            wr_cnt <= wr_acc ? CNT_WIDTH'(1) : '0;
            rd_cnt <= '0;
        end else begin
            wr_cnt <= wr_cnt_inc;
            rd_cnt <= rd_cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_en      <= 1'b0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            rd_en      <= (next_state == STREAM);
            valid_out  <= rd_acc;
            frame_done <= (next_state == DONE);
            ovf_err    <= ovf_err || (valid_core && fifo_full);
        end
    end

endmodule

// File: tb/tb_avgp_out_drain_ctrl.sv
module tb_avgp_out_drain_ctrl;

    localparam int TOTAL = 32;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic       vc [2];
    logic       force_full [2];
    logic       full [2];
    logic       empty [2];
    logic       rd_en [2];
    logic       vout [2];
    logic       fdone [2];
    logic       ovf [2];
    logic [4:0] occ [2];

    int vout_tot [2];
    int done_tot [2];
    int wid_tot [2];
    int rise_cyc [2];
    int rise_occ [2];

    int errors = 0;
    int checks = 0;
    int w8_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int FL = (g == 0) ? 8 : 16;

        // environment: FIFO word count driven by the DUT's real rd_en
        int cnt = 0;
        assign full[g]  = (cnt == DEPTH) || force_full[g];
        assign empty[g] = (cnt == 0);

        always @(posedge clk or posedge reset) begin
            if (reset) cnt <= 0;
            else cnt <= cnt + ((vc[g] && !full[g]) ? 1 : 0) - ((rd_en[g] && !empty[g]) ? 1 : 0);
        end

        avgp_out_drain_ctrl #(
            .IMAGE_WIDTH  (4),
            .IMAGE_HEIGHT (4),
            .CHANNEL_NUM  (2),
            .FILL_LEVEL   (FL),
            .FIFO_DEPTH   (DEPTH),
            .CNT_WIDTH    (18)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .valid_core (vc[g]),
            .fifo_full  (full[g]),
            .fifo_empty (empty[g]),
            .rd_en      (rd_en[g]),
            .valid_out  (vout[g]),
            .frame_done (fdone[g]),
            .ovf_err    (ovf[g]),
            .occupancy  (occ[g])
        );

        // reference: per-frame write/read tallies and a streaming flag
        int m_occ = 0, m_wr = 0, m_rd = 0;
        bit m_in = 0, m_str = 0, e_rd = 0, e_vo = 0, e_fd = 0, e_ovf = 0;
        bit wacc, racc, nd;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                m_occ = 0; m_wr = 0; m_rd = 0; m_in = 0; m_str = 0;
                e_rd = 0; e_vo = 0; e_fd = 0; e_ovf = 0;
            end else begin
                wacc  = vc[g] && !full[g];
                racc  = e_rd && !empty[g];
                e_ovf = e_ovf || (vc[g] && full[g]);
                m_occ = m_occ + (wacc ? 1 : 0) - (racc ? 1 : 0);
                nd = 0;
                if (e_fd) begin
                    m_wr = wacc ? 1 : 0; m_rd = 0; m_in = 0; m_str = 0;
                end else begin
                    if (wacc && m_wr < TOTAL) m_wr++;
                    if (racc) m_rd++;
                    nd = m_str && (m_rd == TOTAL);
                    if (nd) m_str = 0;
                    else if (!m_str && m_in && (m_occ >= FL || m_wr >= TOTAL)) m_str = 1;
                    m_in = (m_wr > 0);
                end
                e_rd = m_str;
                e_fd = nd;
                e_vo = racc;
            end
        end

        always @(negedge clk) begin
            check($sformatf("u%0d.rd_en", g), 32'(rd_en[g]), 32'(e_rd));
            check($sformatf("u%0d.valid_out", g), 32'(vout[g]), 32'(e_vo));
            check($sformatf("u%0d.frame_done", g), 32'(fdone[g]), 32'(e_fd));
            check($sformatf("u%0d.ovf_err", g), 32'(ovf[g]), 32'(e_ovf));
            check($sformatf("u%0d.occupancy", g), 32'(occ[g]), 32'(m_occ));
        end

        int nv = 0, ndn = 0, nwd = 0, since = 0, r_c = 0, r_o = 0;
        bit prev = 0;
        assign vout_tot[g] = nv;
        assign done_tot[g] = ndn;
        assign wid_tot[g]  = nwd;
        assign rise_cyc[g] = r_c;
        assign rise_occ[g] = r_o;

        always @(negedge clk) begin
            if (reset) begin
                since = 0;
                prev  = 0;
            end else begin
                if (vout[g] === 1'b1) begin
                    nv++;
                    since++;
                end
                if (fdone[g] === 1'b1) begin
                    ndn++;
                    check($sformatf("u%0d.done_with_last_pixel", g), 32'(vout[g]), 32'd1);
                    check($sformatf("u%0d.pixels_per_frame", g), 32'(since), 32'(TOTAL));
                    since = 0;
                end
                if (rd_en[g] === 1'b1 && !prev) begin
                    r_c = cyc;
                    r_o = int'(occ[g]);
                end
                prev = (rd_en[g] === 1'b1);
            end
        end

        always @(posedge clk) begin
            if (!reset && fdone[g] === 1'b1 && vc[g] && !full[g]) nwd++;
        end
    end

    // mode: 1 = every cycle, 3 = every third cycle, 0 = random
    task automatic drive(input int g, input int n, input int mode);
        int left;
        int k;
        int guard;
        bit want;
        left = n;
        k = 0;
        guard = 0;
        while (left > 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
            want = (mode == 0) ? ($urandom_range(0, 1) == 1) : (k % mode == 0);
            if (want && !full[g]) begin
                vc[g] = 1'b1;
                left--;
                if (n - left == 8) w8_cyc = cyc;
            end else begin
                vc[g] = 1'b0;
            end
            k++;
        end
        @(negedge clk);
        vc[g] = 1'b0;
        check("drive_budget", 32'(left), 32'd0);
    endtask

    task automatic wait_done(input int g, input int target);
        int t;
        t = 0;
        while (done_tot[g] < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("frame_done_timeout", 32'(done_tot[g] >= target), 32'd1);
        repeat (4) @(negedge clk);
    endtask

    int bv, bd, bw;

    initial begin
        vc[0] = 1'b0; vc[1] = 1'b0;
        force_full[0] = 1'b0; force_full[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("reset.rd_en", 32'(rd_en[g]), 32'd0);
            check("reset.valid_out", 32'(vout[g]), 32'd0);
            check("reset.frame_done", 32'(fdone[g]), 32'd0);
            check("reset.ovf_err", 32'(ovf[g]), 32'd0);
            check("reset.occupancy", 32'(occ[g]), 32'd0);
        end
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        // continuous writes, FILL_LEVEL 8
        bv = vout_tot[0]; bd = done_tot[0];
        drive(0, 32, 1);
        wait_done(0, bd + 1);
        check("s1.pixels", 32'(vout_tot[0] - bv), 32'd32);
        check("s1.frames", 32'(done_tot[0] - bd), 32'd1);
        check("s1.rd_en_after_8th_write", 32'(rise_cyc[0] - w8_cyc), 32'd1);
        check("s1.start_occupancy", 32'(rise_occ[0]), 32'd8);
        check("s1.ovf_err", 32'(ovf[0]), 32'd0);

        // every third cycle
        bv = vout_tot[0]; bd = done_tot[0];
        drive(0, 32, 3);
        wait_done(0, bd + 1);
        check("s2.pixels", 32'(vout_tot[0] - bv), 32'd32);
        check("s2.frames", 32'(done_tot[0] - bd), 32'd1);
        check("s2.start_occupancy", 32'(rise_occ[0]), 32'd8);

        // FILL_LEVEL equal to the FIFO depth
        bv = vout_tot[1]; bd = done_tot[1];
        drive(1, 32, 1);
        wait_done(1, bd + 1);
        check("s3.pixels", 32'(vout_tot[1] - bv), 32'd32);
        check("s3.frames", 32'(done_tot[1] - bd), 32'd1);
        check("s3.start_occupancy", 32'(rise_occ[1]), 32'd16);

        // back-to-back frames, a write lands in the DONE cycle
        bv = vout_tot[0]; bd = done_tot[0]; bw = wid_tot[0];
        drive(0, 64, 1);
        wait_done(0, bd + 2);
        check("s6.pixels", 32'(vout_tot[0] - bv), 32'd64);
        check("s6.frames", 32'(done_tot[0] - bd), 32'd2);
        check("s6.write_in_done", 32'(wid_tot[0] - bw > 0), 32'd1);
        check("s6.drained", 32'(occ[0]), 32'd0);

        // write attempted while full
        @(negedge clk);
        force_full[0] = 1'b1; vc[0] = 1'b1;
        @(negedge clk);
        force_full[0] = 1'b0; vc[0] = 1'b0;
        check("s4.ovf_set", 32'(ovf[0]), 32'd1);
        check("s4.lost_write_uncounted", 32'(occ[0]), 32'd0);
        bv = vout_tot[0]; bd = done_tot[0];
        drive(0, 32, 1);
        wait_done(0, bd + 1);
        check("s4.pixels", 32'(vout_tot[0] - bv), 32'd32);
        check("s4.frames", 32'(done_tot[0] - bd), 32'd1);
        check("s4.ovf_sticky", 32'(ovf[0]), 32'd1);

        // asynchronous reset in the middle of streaming
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            vc[0] = !full[0];
        end
        @(negedge clk);
        vc[0] = 1'b0;
        check("s5.streaming_before_reset", 32'(rd_en[0]), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("s5.rd_en_cleared", 32'(rd_en[0]), 32'd0);
        check("s5.valid_out_cleared", 32'(vout[0]), 32'd0);
        check("s5.frame_done_cleared", 32'(fdone[0]), 32'd0);
        check("s5.ovf_cleared", 32'(ovf[0]), 32'd0);
        check("s5.occupancy_cleared", 32'(occ[0]), 32'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        bv = vout_tot[0]; bd = done_tot[0];
        drive(0, 32, 1);
        wait_done(0, bd + 1);
        check("s5.pixels", 32'(vout_tot[0] - bv), 32'd32);
        check("s5.frames", 32'(done_tot[0] - bd), 32'd1);

        // random write patterns on both instances
        for (int r = 0; r < 6; r++) begin
            int g;
            g = r % 2;
            bv = vout_tot[g]; bd = done_tot[g];
            drive(g, 32, 0);
            wait_done(g, bd + 1);
            check("rand.pixels", 32'(vout_tot[g] - bv), 32'd32);
            check("rand.frames", 32'(done_tot[g] - bd), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
